morse_player: RTL and testbench
===============================

// Module: morse_player
// PURPOSE
//  Plays stored Morse letter codes out as timed on/off keying on an LED or buzzer pin.
//  It takes the 16-bit letter codes built by the button-entry path: dot = "10", dash = "1110".
//  Codes are right-aligned, the MSB is the first element, and a trailing 0 ends each element.
//  Sits between the letter registers (sseg1..sseg5) and the board LED.
//  Each code bit is held for one Morse unit; letter and word spacing are added automatically.
// PARAMETERS
//  UNIT_TICKS  12_500_000  clock cycles per Morse unit (125 ms at 100 MHz); must be >= 2
//  CNT_W       24          width of the unit counter; 2**CNT_W > UNIT_TICKS
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  code_in      in   16  letter code; 16'h0000 = word space
//  code_valid   in   1   code_in is valid
//  code_ready   out  1   block is IDLE and can accept a code
//  abort        in   1   synchronous stop; drops the current letter
//  key_out      out  1   keying output: 1 = tone/LED on
//  busy         out  1   playing a letter or a gap
//  letter_done  out  1   one-cycle pulse when a letter or space completes normally
// BEHAVIOUR
//  - Reset is asynchronous; clock is the system clock. Reset forces all of the following:
//    - state = IDLE; key_out, busy, letter_done = 0; code_ready = 1
//    - unit counter and bit pointer = 0
//    - reset mid-letter truncates the output immediately; no done pulse
//  - Handshake:
//    - accept when code_valid & code_ready at a rising edge; code_in is latched into shreg
//    - code_ready = (state == IDLE) & ~abort
//  - States:
//    - IDLE -> PLAY when the accepted code != 0
//      - ptr = index of the highest set bit (0..15)
//    - IDLE -> GAP when the accepted code == 0; gap_units = 4
//    - PLAY: key_out = shreg[ptr] (registered), held for UNIT_TICKS cycles
//      - then ptr decrements
//      - after bit 0 has been played: -> GAP with gap_units = 2
//      - the trailing 0 already supplies 1 unit, giving 3 units of letter gap in total
//    - GAP: key_out = 0 for gap_units * UNIT_TICKS cycles, then -> IDLE
//      - letter_done = 1 in the first IDLE cycle
//      - word space: 4 units plus the prior letter's 3 units = 7 units
//  - Latency: the first element appears on key_out in the cycle after acceptance (t0+1).
//  - Back-to-back:
//    - a new code is accepted in the cycle letter_done is high
//    - code_valid held high gives continuous playback with no extra idle cycle
//  - Unit counter:
//    - counts 0..UNIT_TICKS-1, clears on every unit boundary and on accept
//    - counter wrap is the only timing event
//  - Abort (any state):
//    - next cycle: state = IDLE, key_out = 0, no letter_done
//    - abort wins over a simultaneous code_valid; no accept in that cycle
//  - Malformed code (bit0 = 1):
//    - played verbatim, gap still 2 units; no error flag
//  - busy = (state != IDLE); key_out = 0 whenever state != PLAY
// STRUCTURE
//  - morse_pkg.vh holds:
//    - CODE_W = 16, LETTER_GAP_UNITS = 2, SPACE_GAP_UNITS = 4
//    - state encodings IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2
//    - shared with the entry path's element encodings DOT = 2'b10, DASH = 4'b1110
//  - Sub-module morse_msb_find: combinational 16-bit priority encoder
//    - outputs msb_idx[3:0] and nonzero; used at accept
//  - Top level: FSM, unit counter, gap-unit counter, 4-bit bit pointer
// TESTING (sim with UNIT_TICKS=4; t0 = accept edge)
//  1. 'A' = 16'h002E (101110):
//     - key_out pattern 1x4, 0x4, 1x12, 0x4 over t0+1..t0+24
//     - then 0 for 8 cycles; letter_done = 1 at t0+33
//  2. 'E' = 16'h0002:
//     - key_out = 1 at t0+1..t0+4, 0 at t0+5..t0+16; letter_done at t0+17
//  3. Space = 16'h0000:
//     - key_out stays 0 and busy = 1 for 16 cycles; letter_done at t0+17
//  4. Back-to-back 16'h0002 then 16'h002E with code_valid held high:
//     - second code accepted at t0+17 and its first element appears at t0+18
//     - exactly one letter_done per letter
//  5. Abort asserted at t0+10 during 'A':
//     - key_out = 0 and code_ready = 1 at t0+11; letter_done never asserts
//     - abort + code_valid together in IDLE: no accept
//  6. Async reset pulse mid-dash (t0+14):
//     - key_out = 0 and busy = 0 immediately, code_ready = 1
//     - a new 16'h0002 accepted after release plays correctly

Source files
------------

// File: rtl/morse_player_pkg.sv
// Shared constants for the Morse playback path.
//   CODE_W            width of a stored letter code
//   LETTER_GAP_UNITS  silent units appended after a letter (trailing 0 adds one more)
//   SPACE_GAP_UNITS   silent units played for a word-space code (16'h0000)
//   DOT / DASH        element encodings used by the button-entry path
//   state_t           playback FSM states
package morse_player_pkg;

  localparam int CODE_W           = 16;
  localparam int PTR_W            = 4;
  localparam int GAP_W            = 3;
  localparam int LETTER_GAP_UNITS = 2;
  localparam int SPACE_GAP_UNITS  = 4;

  localparam logic [1:0] DOT  = 2'b10;
  localparam logic [3:0] DASH = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/morse_player_if.sv
// Letter-code handshake between the letter registers and the player.
//   code_in     right-aligned letter code (0 = word space)
//   code_valid  code_in is valid
//   code_ready  player can take a code this cycle
// master = code source, slave = player.
interface morse_player_if;
  import morse_player_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;

  modport master (output code_in, output code_valid, input code_ready);
  modport slave  (input code_in, input code_valid, output code_ready);

endinterface

// File: rtl/morse_player_msb_find.sv
// Combinational priority encoder: index of the highest set bit of a code.
//   code     letter code
//   msb_idx  index of the highest set bit (0 when code is zero)
//   nonzero  code has at least one set bit
module morse_player_msb_find
  import morse_player_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [PTR_W-1:0]  msb_idx,
  output logic              nonzero
);

  // Ascending scan: the last set bit seen wins, i.e. the highest one.
  always_comb begin
    msb_idx = '0;
    nonzero = |code;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) msb_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/morse_player.sv
// Plays a stored Morse letter code as timed on/off keying.
// Each code bit is held for one unit (UNIT_TICKS clocks), MSB first from the
// highest set bit; a letter is followed by 2 silent units, a zero code plays
// 4 silent units (word space).
//   clock, reset   system clock, async active-high reset
//   code_bus       letter-code handshake (slave side)
//   abort          synchronous stop, drops the current letter
//   key_out        keying output, 1 = tone/LED on
//   busy           playing a letter or a gap
//   letter_done    one-cycle pulse when a letter or space ends normally
module morse_player
  import morse_player_pkg::*;
#(
  parameter int UNIT_TICKS = 12_500_000,
  parameter int CNT_W      = 24
) (
  input  logic           clock,
  input  logic           reset,
  morse_player_if.slave  code_bus,
  input  logic           abort,
  output logic           key_out,
  output logic           busy,
  output logic           letter_done
);

  localparam logic [CNT_W-1:0] UNIT_LAST  = CNT_W'(UNIT_TICKS - 1);
  localparam logic [GAP_W-1:0] LETTER_GAP = GAP_W'(LETTER_GAP_UNITS);
  localparam logic [GAP_W-1:0] SPACE_GAP  = GAP_W'(SPACE_GAP_UNITS);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [GAP_W-1:0]  gap, gap_n;
  logic [CODE_W-1:0] shreg, shreg_n;
  logic              key_n, done_n;

  logic [PTR_W-1:0]  msb_idx;
  logic              nonzero;
  logic              unit_end;

  morse_player_msb_find u_msb_find (
    .code    (code_bus.code_in),
    .msb_idx (msb_idx),
    .nonzero (nonzero)
  );

  assign unit_end            = (cnt == UNIT_LAST);
  assign code_bus.code_ready = (state == IDLE) & ~abort;
  assign busy                = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      gap         <= '0;
      shreg       <= '0;
      key_out     <= 1'b0;
      letter_done <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      gap         <= gap_n;
      shreg       <= shreg_n;
      key_out     <= key_n;
      letter_done <= done_n;
    end
  end

  // key_out is registered, so the next element is loaded at the edge that
  // ends the current unit; the first element is loaded at the accept edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gap_n   = gap;
    shreg_n = shreg;
    key_n   = key_out;
    done_n  = 1'b0;

    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      ptr_n   = '0;
      gap_n   = '0;
      key_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (code_bus.code_valid) begin
            shreg_n = code_bus.code_in;
            cnt_n   = '0;
            if (nonzero) begin
              state_n = PLAY;
              ptr_n   = msb_idx;
              key_n   = code_bus.code_in[msb_idx];
            end else begin
              state_n = GAP;
              gap_n   = SPACE_GAP;
              key_n   = 1'b0;
            end
          end
        end
        PLAY: begin
          if (unit_end) begin
            cnt_n = '0;
            if (ptr == '0) begin
              state_n = GAP;
              gap_n   = LETTER_GAP;
              key_n   = 1'b0;
            end else begin
              ptr_n = ptr - PTR_W'(1);
              key_n = shreg[ptr - PTR_W'(1)];
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (unit_end) begin
            cnt_n = '0;
            if (gap == GAP_W'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              gap_n = gap - GAP_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          key_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench for morse_player with UNIT_TICKS = 4.
// Each accepted code pushes its expected per-cycle {key_out, busy, letter_done}
// trace; a negedge monitor pops one entry per cycle and compares.
module tb_morse_player;
  import morse_player_pkg::*;

  localparam int UT = 4;

  typedef struct packed {
    logic key;
    logic busy;
    logic done;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;
  logic key_out, busy, letter_done;

  morse_player_if bus ();

  morse_player #(.UNIT_TICKS(UT), .CNT_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .code_bus    (bus.slave),
    .abort       (abort),
    .key_out     (key_out),
    .busy        (busy),
    .letter_done (letter_done)
  );

  always #5 clock = ~clock;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent model of one code's playback, truncated to lim cycles.
  task automatic push_trace(input logic [15:0] c, input int lim);
    exp_t t[$];
    int   top;
    if (c == 16'h0000) begin
      repeat (SPACE_GAP_UNITS * UT) t.push_back('{1'b0, 1'b1, 1'b0});
    end else begin
      top = 0;
      for (int i = 0; i < 16; i++) if (c[i]) top = i;
      for (int i = top; i >= 0; i--)
        repeat (UT) t.push_back('{c[i], 1'b1, 1'b0});
      repeat (LETTER_GAP_UNITS * UT) t.push_back('{1'b0, 1'b1, 1'b0});
    end
    t.push_back('{1'b0, 1'b0, 1'b1});
    for (int i = 0; i < t.size() && i < lim; i++) exp_q.push_back(t[i]);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("key_out", 32'(key_out), 32'(e.key));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("letter_done", 32'(letter_done), 32'(e.done));
    end
  end

  // Present a code, wait for it to be taken, push its expected trace.
  task automatic send(input logic [15:0] c, input int lim, input bit hold);
    int n;
    @(negedge clock);
    bus.code_in    = c;
    bus.code_valid = 1'b1;
    n = 0;
    while (!bus.code_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clock);
    push_trace(c, lim);
    #1;
    if (!hold) bus.code_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    #1;
    chk("idle_key", 32'(key_out), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(bus.code_ready), 32'd1);
  endtask

  logic [15:0] code_a, code_e, code_q;
  int          k, dones;

  initial begin
    bus.code_in    = '0;
    bus.code_valid = 1'b0;
    code_a = 16'({DOT, DASH});                     // 16'h002E
    code_e = 16'({DOT});                           // 16'h0002
    code_q = 16'({DASH, DASH, DOT, DASH});         // 16'h3BAE

    // reset state
    #12;
    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(letter_done), 32'd0);
    chk("rst_ready", 32'(bus.code_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // single letters, word space, long and malformed / boundary codes
    chk("code_a_const", 32'(code_a), 32'h2E);
    send(code_a, 1000, 1'b0); drain();
    send(code_e, 1000, 1'b0); drain();
    send(16'h0000, 1000, 1'b0); drain();
    send(code_q, 1000, 1'b0); drain();
    send(16'h0007, 1000, 1'b0); drain();
    send(16'h8001, 1000, 1'b0); drain();

    // back-to-back with code_valid held
    send(code_e, 1000, 1'b1);
    @(negedge clock);
    bus.code_in = code_a;
    k = 1;
    while (!bus.code_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("b2b_accept_cycle", 32'(k), 32'd17);
    @(posedge clock);
    push_trace(code_a, 1000);
    #1;
    bus.code_valid = 1'b0;
    drain();

    // abort during 'A' at t0+10, then abort + valid while idle
    send(code_a, 10, 1'b0);
    repeat (10) @(negedge clock);
    #1;
    abort          = 1'b1;
    bus.code_in    = code_e;
    bus.code_valid = 1'b1;
    @(posedge clock); #1;
    chk("abort_key", 32'(key_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(letter_done), 32'd0);
    chk("abort_ready_held", 32'(bus.code_ready), 32'd0);
    @(posedge clock); #1;
    chk("abort_no_accept", 32'(busy), 32'd0);
    bus.code_valid = 1'b0;
    abort          = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.code_ready), 32'd1);
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (letter_done || key_out) dones++;
    end
    chk("abort_quiet", 32'(dones), 32'd0);

    // async reset in the middle of the dash
    send(code_a, 13, 1'b0);
    repeat (14) @(negedge clock);
    #1;
    chk("pre_reset_key", 32'(key_out), 32'd1);
    reset = 1'b1;
    #1;
    chk("areset_key", 32'(key_out), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_ready", 32'(bus.code_ready), 32'd1);
    @(negedge clock);
    chk("areset_done", 32'(letter_done), 32'd0);
    reset = 1'b0;
    send(code_e, 1000, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
